// File: rtl/ram1_uart_bus_ctrl_pkg.sv
// rtl/ram1_uart_bus_ctrl_pkg.sv - shared states, UART address map and status-word layout
package ram1_uart_bus_ctrl_pkg;

    localparam logic [15:0] UART_DATA_ADR_DEF = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADR_DEF = 16'hBF01;

    localparam int unsigned STAT_TX_IDLE_BIT  = 0;
    localparam int unsigned STAT_RX_READY_BIT = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM_RD,
        S_RAM_WR,
        S_UART_RD,
        S_UART_WR,
        S_UART_WAIT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        TGT_RAM,
        TGT_UART_DATA,
        TGT_UART_STAT
    } target_e;

    function automatic target_e decode_addr(input logic [15:0] addr,
                                            input logic [15:0] data_adr,
                                            input logic [15:0] stat_adr);
        if (addr == data_adr) return TGT_UART_DATA;
        if (addr == stat_adr) return TGT_UART_STAT;
        return TGT_RAM;
    endfunction

    function automatic logic [15:0] status_word(input logic rx_ready, input logic tx_idle);
        logic [15:0] w;
        w = '0;
        w[STAT_RX_READY_BIT] = rx_ready;
        w[STAT_TX_IDLE_BIT]  = tx_idle;
        return w;
    endfunction

endpackage

// File: rtl/ram1_uart_bus_ctrl_if.sv
// rtl/ram1_uart_bus_ctrl_if.sv - CPU-side IF/MEM request and acknowledge bundle
interface ram1_uart_bus_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic              if_req;
    logic [15:0]       if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              mem_req;
    logic              mem_we;
    logic [15:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
        output if_rdata, if_ack, mem_rdata, mem_ack
    );
endinterface

// File: rtl/ram1_uart_bus_ctrl_uart_seq.sv
// rtl/ram1_uart_bus_ctrl_uart_seq.sv - UART rdn/wrn strobes and transmitter-idle wait
module uart_strobe_seq
    import ram1_uart_bus_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   tsre_i,
    input  logic   tbre_i,
    output logic   rdn_o,
    output logic   wrn_o,
    output logic   tx_idle_o,
    output logic   wait_done_o
);
    // Strobes decode straight from the state so an async reset releases them at once.
    assign rdn_o       = (state_i != S_UART_RD);
    assign wrn_o       = (state_i != S_UART_WR);
    assign tx_idle_o   = tsre_i & tbre_i;
    assign wait_done_o = (state_i == S_UART_WAIT) && tx_idle_o;
endmodule

// File: rtl/ram1_uart_bus_ctrl.sv
// rtl/ram1_uart_bus_ctrl.sv - arbitrates IF/MEM onto the shared RAM1/UART board bus
module ram1_uart_bus_ctrl
    import ram1_uart_bus_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ADDR_W        = 18,
    parameter logic [15:0] UART_DATA_ADR = UART_DATA_ADR_DEF,
    parameter logic [15:0] UART_STAT_ADR = UART_STAT_ADR_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    ram1_uart_bus_ctrl_if.slave  cpu,
    inout  wire  [DATA_W-1:0]    ram1_data,
    output logic [ADDR_W-1:0]    ram1_addr,
    output logic                 ram1_en,
    output logic                 ram1_oe,
    output logic                 ram1_we,
    input  logic                 tsre,
    input  logic                 tbre,
    input  logic                 data_ready,
    output logic                 rdn,
    output logic                 wrn,
    output logic                 busy
);
    state_e              state_q, state_d;
    logic                serve_mem_q, serve_mem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                wr_hold_q, wr_hold_d;
    logic                tx_idle, wait_done, data_oe;

    uart_strobe_seq u_uart_seq (
        .state_i     (state_q),
        .tsre_i      (tsre),
        .tbre_i      (tbre),
        .rdn_o       (rdn),
        .wrn_o       (wrn),
        .tx_idle_o   (tx_idle),
        .wait_done_o (wait_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            serve_mem_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            wr_hold_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            serve_mem_q <= serve_mem_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            wr_hold_q   <= wr_hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        serve_mem_d = serve_mem_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        // Keeps store data on the bus for the DONE cycle after the SRAM we rises.
        wr_hold_d   = (state_q == S_RAM_WR);
        case (state_q)
            S_IDLE: begin
                if (cpu.mem_req) begin
                    serve_mem_d = 1'b1;
                    addr_d      = ADDR_W'(cpu.mem_addr);
                    wdata_d     = cpu.mem_wdata;
                    case (decode_addr(cpu.mem_addr, UART_DATA_ADR, UART_STAT_ADR))
                        TGT_UART_STAT: begin
                            if (!cpu.mem_we) mem_rdata_d = status_word(data_ready, tx_idle);
                            state_d = S_DONE;
                        end
                        TGT_UART_DATA: state_d = cpu.mem_we ? S_UART_WR : S_UART_RD;
                        default:       state_d = cpu.mem_we ? S_RAM_WR : S_RAM_RD;
                    endcase
                end else if (cpu.if_req) begin
                    serve_mem_d = 1'b0;
                    addr_d      = ADDR_W'(cpu.if_addr);
                    state_d     = S_RAM_RD;
                end
            end
            S_RAM_RD, S_UART_RD: begin
                if (serve_mem_q) mem_rdata_d = ram1_data;
                else             if_rdata_d  = ram1_data;
                state_d = S_DONE;
            end
            S_RAM_WR:    state_d = S_DONE;
            S_UART_WR:   state_d = S_UART_WAIT;
            S_UART_WAIT: if (wait_done) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    assign data_oe   = (state_q == S_RAM_WR) || (state_q == S_UART_WR) || wr_hold_q;
    assign ram1_data = data_oe ? wdata_q : {DATA_W{1'bz}};
    assign ram1_addr = addr_q;
    assign ram1_en   = !((state_q == S_RAM_RD) || (state_q == S_RAM_WR));
    assign ram1_oe   = (state_q != S_RAM_RD);
    assign ram1_we   = (state_q != S_RAM_WR);
    assign busy      = (state_q != S_IDLE);

    assign cpu.if_rdata  = if_rdata_q;
    assign cpu.mem_rdata = mem_rdata_q;
    assign cpu.if_ack    = (state_q == S_DONE) && !serve_mem_q;
    assign cpu.mem_ack   = (state_q == S_DONE) && serve_mem_q;
endmodule

// File: tb/tb_ram1_uart_bus_ctrl.sv
// tb/tb_ram1_uart_bus_ctrl.sv - randomized bench with SRAM/UART device models and a word-level reference
module tb_ram1_uart_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] ram1_data;
    logic [17:0] ram1_addr;
    logic        ram1_en, ram1_oe, ram1_we, rdn, wrn, busy;
    logic        tsre, tbre, data_ready;

    ram1_uart_bus_ctrl_if cpu ();

    ram1_uart_bus_ctrl dut (
        .clk(clk), .rst(rst), .cpu(cpu),
        .ram1_data(ram1_data), .ram1_addr(ram1_addr),
        .ram1_en(ram1_en), .ram1_oe(ram1_oe), .ram1_we(ram1_we),
        .tsre(tsre), .tbre(tbre), .data_ready(data_ready),
        .rdn(rdn), .wrn(wrn), .busy(busy)
    );

    always #5 clk = ~clk;

    // Board devices: SRAM array and a UART that returns uart_rx while rdn is low.
    logic [15:0] sram [0:262143];
    logic [15:0] uart_rx;
    logic [15:0] tx_last;
    logic        dev_en;
    logic [15:0] dev_val;
    assign dev_en    = (!ram1_en && !ram1_oe) || !rdn;
    assign dev_val   = !rdn ? uart_rx : sram[ram1_addr];
    assign ram1_data = dev_en ? dev_val : 16'hzzzz;

    always @(posedge clk) begin
        if (!ram1_en && !ram1_we) sram[ram1_addr] <= ram1_data;
        if (!wrn) tx_last <= ram1_data;
    end

    int wrn_low = 0, rdn_low = 0, we_low = 0, contention = 0;
    always @(negedge clk) begin
        if (!wrn) wrn_low++;
        if (!rdn) rdn_low++;
        if (!ram1_we) we_low++;
        if ((!rdn || !wrn) && !ram1_en) contention++;
    end

    int n_checks = 0, n_errors = 0;
    logic [15:0] ref_mem [logic [15:0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_status(input logic dr, input logic ts, input logic tb);
        return {14'b0, dr, ts & tb};
    endfunction

    // Issues one MEM request from a negedge; returns the cycle (grant cycle = 1) in which ack was seen.
    task automatic mem_op(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                          output logic [15:0] rd, output int cyc);
        cpu.mem_req = 1'b1; cpu.mem_we = we; cpu.mem_addr = addr; cpu.mem_wdata = wd;
        cyc = 1;
        while (!cpu.mem_ack && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("mem_ack_seen", cpu.mem_ack, 1);
        rd = cpu.mem_rdata;
        cpu.mem_req = 1'b0;
        @(negedge clk);
        check_eq("mem_ack_pulse", cpu.mem_ack, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd, wd, a, fa;
        logic [15:0] pool [8];
        int cyc, s0, s1, n, mem_c, if_c, mem_n, if_n, acks, ta, tb_, exp_c, kind;

        rst = 1'b0; tsre = 1'b1; tbre = 1'b1; data_ready = 1'b0; uart_rx = 16'h0;
        cpu.if_req = 1'b0; cpu.if_addr = '0; cpu.mem_req = 1'b0; cpu.mem_we = 1'b0;
        cpu.mem_addr = '0; cpu.mem_wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_strobes", {ram1_en, ram1_oe, ram1_we, rdn, wrn}, 5'b11111);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_addr", ram1_addr, 0);
        check_eq("rst_acks", {cpu.if_ack, cpu.mem_ack}, 0);
        check_eq("rst_rdata", {cpu.if_rdata, cpu.mem_rdata}, 0);
        rst = 1'b1;
        @(negedge clk);

        // RAM store then load
        s0 = we_low;
        mem_op(1'b1, 16'h4000, 16'h1234, rd, cyc);
        ref_mem[16'h4000] = 16'h1234;
        check_eq("t1_store_cyc", cyc, 3);
        check_eq("t1_we_low_cycles", we_low - s0, 1);
        mem_op(1'b0, 16'h4000, 16'h0, rd, cyc);
        check_eq("t1_load_cyc", cyc, 3);
        check_eq("t1_load_data", rd, 16'h1234);

        // Status and UART data reads
        data_ready = 1'b1; tsre = 1'b1; tbre = 1'b1;
        mem_op(1'b0, 16'hBF01, 16'h0, rd, cyc);
        check_eq("t4_status", rd, 16'h0003);
        check_eq("t4_status_cyc", cyc, 2);
        uart_rx = 16'h00C5; s0 = rdn_low;
        mem_op(1'b0, 16'hBF00, 16'h0, rd, cyc);
        check_eq("t4_uart_rd", rd, 16'h00C5);
        check_eq("t4_uart_rd_cyc", cyc, 3);
        check_eq("t4_rdn_low_cycles", rdn_low - s0, 1);

        // UART writes held off by tbre/tsre; first one fixed, then random release times
        for (int it = 0; it < 4; it++) begin
            ta  = (it == 0) ? 12 : $urandom_range(2, 14);
            tb_ = (it == 0) ? 1  : $urandom_range(1, 14);
            wd  = (it == 0) ? 16'h0041 : 16'($urandom_range(0, 255));
            exp_c = ((ta > tb_) ? ta : tb_);
            exp_c = ((exp_c > 3) ? exp_c : 3) + 1;
            tbre = 1'b0; tsre = (tb_ <= 1);
            s0 = wrn_low;
            cpu.mem_req = 1'b1; cpu.mem_we = 1'b1; cpu.mem_addr = 16'hBF00; cpu.mem_wdata = wd;
            mem_c = 0;
            for (int c = 2; c <= 40 && mem_c == 0; c++) begin
                @(negedge clk);
                if (cpu.mem_ack) mem_c = c;
                if (c == ta)  tbre = 1'b1;
                if (c == tb_) tsre = 1'b1;
            end
            cpu.mem_req = 1'b0;
            check_eq("t3_uart_wr_ack_cyc", mem_c, exp_c);
            check_eq("t3_wrn_low_cycles", wrn_low - s0, 1);
            check_eq("t3_tx_data", tx_last, wd);
            @(negedge clk);
            check_eq("t3_ack_pulse", cpu.mem_ack, 0);
            tbre = 1'b1; tsre = 1'b1;
        end

        // IF burst of four fetches
        for (int k = 0; k < 4; k++) begin
            wd = 16'($urandom);
            mem_op(1'b1, 16'h0100 + 16'(k), wd, rd, cyc);
            ref_mem[16'h0100 + 16'(k)] = wd;
        end
        fa = 16'h0100; cpu.if_addr = fa; cpu.if_req = 1'b1; n = 0;
        for (int c = 2; c <= 30 && n < 4; c++) begin
            @(negedge clk);
            if (cpu.if_ack) begin
                check_eq("t6_if_ack_cyc", c, 3 * (n + 1));
                check_eq("t6_if_data", cpu.if_rdata, ref_mem[fa]);
                n++;
                fa = fa + 16'd1;
                cpu.if_addr = fa;
                if (n == 4) cpu.if_req = 1'b0;
            end
        end
        check_eq("t6_if_count", n, 4);
        @(negedge clk);

        // Collision: MEM wins, IF follows three cycles later
        cpu.if_addr = 16'h0102; cpu.if_req = 1'b1;
        cpu.mem_addr = 16'h4000; cpu.mem_we = 1'b0; cpu.mem_req = 1'b1;
        mem_c = 0; if_c = 0; mem_n = 0; if_n = 0;
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            if (cpu.mem_ack) begin
                mem_n++; mem_c = c; cpu.mem_req = 1'b0;
                check_eq("t2_mem_data", cpu.mem_rdata, ref_mem[16'h4000]);
            end
            if (cpu.if_ack) begin
                if_n++; if_c = c; cpu.if_req = 1'b0;
                check_eq("t2_if_data", cpu.if_rdata, ref_mem[16'h0102]);
            end
        end
        check_eq("t2_mem_ack_cyc", mem_c, 3);
        check_eq("t2_if_ack_cyc", if_c, 6);
        check_eq("t2_ack_counts", {mem_n[7:0], if_n[7:0]}, 16'h0101);

        // Randomized MEM traffic against the reference
        pool[0] = 16'h0000; pool[1] = 16'hFFFF; pool[2] = 16'h4000; pool[3] = 16'hBEFF;
        pool[4] = 16'hBF02;
        for (int k = 5; k < 8; k++) pool[k] = 16'($urandom_range(0, 16'hBEFF));
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 5);
            a = pool[$urandom_range(0, 7)];
            if (kind == 1 && !ref_mem.exists(a)) kind = 0;
            case (kind)
                0: begin
                    wd = 16'($urandom);
                    mem_op(1'b1, a, wd, rd, cyc);
                    ref_mem[a] = wd;
                    check_eq("rnd_ram_wr_cyc", cyc, 3);
                end
                1: begin
                    mem_op(1'b0, a, 16'h0, rd, cyc);
                    check_eq("rnd_ram_rd_data", rd, ref_mem[a]);
                    check_eq("rnd_ram_rd_cyc", cyc, 3);
                end
                2: begin
                    data_ready = 1'($urandom); tsre = 1'($urandom); tbre = 1'($urandom);
                    mem_op(1'b0, 16'hBF01, 16'h0, rd, cyc);
                    check_eq("rnd_status", rd, exp_status(data_ready, tsre, tbre));
                    check_eq("rnd_status_cyc", cyc, 2);
                end
                3: begin
                    uart_rx = 16'($urandom_range(0, 255));
                    mem_op(1'b0, 16'hBF00, 16'h0, rd, cyc);
                    check_eq("rnd_uart_rd", rd, uart_rx);
                    check_eq("rnd_uart_rd_cyc", cyc, 3);
                end
                4: begin
                    s0 = we_low; s1 = wrn_low;
                    mem_op(1'b1, 16'hBF01, 16'($urandom), rd, cyc);
                    check_eq("rnd_stat_wr_cyc", cyc, 2);
                    check_eq("rnd_stat_wr_no_strobe", (we_low - s0) + (wrn_low - s1), 0);
                end
                default: begin
                    tsre = 1'b1; tbre = 1'b1;
                    wd = 16'($urandom_range(0, 255));
                    mem_op(1'b1, 16'hBF00, wd, rd, cyc);
                    check_eq("rnd_uart_wr_cyc", cyc, 4);
                    check_eq("rnd_uart_wr_data", tx_last, wd);
                end
            endcase
        end

        // Reset while parked in UART_WAIT
        tsre = 1'b0; tbre = 1'b0;
        cpu.mem_req = 1'b1; cpu.mem_we = 1'b1; cpu.mem_addr = 16'hBF00; cpu.mem_wdata = 16'h0055;
        repeat (5) @(negedge clk);
        check_eq("t5_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        check_eq("t5_strobes", {ram1_en, ram1_oe, ram1_we, rdn, wrn}, 5'b11111);
        check_eq("t5_bus_released", dut.data_oe, 0);
        check_eq("t5_busy", busy, 0);
        cpu.mem_req = 1'b0; tsre = 1'b1; tbre = 1'b1;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            acks += int'(cpu.mem_ack) + int'(cpu.if_ack);
        end
        check_eq("t5_no_ack", acks, 0);
        check_eq("t5_rdata_cleared", cpu.mem_rdata, 0);
        rst = 1'b1;
        @(negedge clk);
        mem_op(1'b0, 16'h4000, 16'h0, rd, cyc);
        check_eq("t5_after_rst_data", rd, ref_mem[16'h4000]);
        check_eq("t5_after_rst_cyc", cyc, 3);

        check_eq("no_bus_contention", contention, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
